// File: rtl/vc_sched_pkg.sv
// vc_sched_pkg: shared definitions for the VC read scheduler.
//   - default channel count and grant index width
//   - FSM state encodings (exposed on state_out, so the values are fixed)
//   - idx_w(): index width helper that never returns zero
package vc_sched_pkg;

    localparam int unsigned NumVcDef = 4;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned GRANT_W = idx_w(NumVcDef);

    localparam logic [2:0] StReset  = 3'd0;
    localparam logic [2:0] StInit   = 3'd1;
    localparam logic [2:0] StIdle   = 3'd2;
    localparam logic [2:0] StActive = 3'd3;
    localparam logic [2:0] StError  = 3'd4;

endpackage

// File: rtl/vc_read_scheduler_if.sv
// vc_read_scheduler_if: bundle between the FIFO bank / output mux side (master)
// and the scheduler (slave).
//   master drives : init, high/low_limit_in, fifo_empty/full/error, dest_pause
//   slave drives  : fifo_read, grant_id, high/low_limit, state_out, idle/active/error_out
interface vc_read_scheduler_if #(
    parameter int unsigned NUM_VC    = vc_sched_pkg::NumVcDef,
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned GRANT_W   = vc_sched_pkg::idx_w(NUM_VC)
) ();

    logic                 init;
    logic [ADDR_BITS-1:0] high_limit_in;
    logic [ADDR_BITS-1:0] low_limit_in;
    logic [NUM_VC-1:0]    fifo_empty;
    logic [NUM_VC-1:0]    fifo_full;
    logic [NUM_VC-1:0]    fifo_error;
    logic [NUM_VC-1:0]    dest_pause;

    logic [NUM_VC-1:0]    fifo_read;
    logic [GRANT_W-1:0]   grant_id;
    logic [ADDR_BITS-1:0] high_limit;
    logic [ADDR_BITS-1:0] low_limit;
    logic [2:0]           state_out;
    logic                 idle_out;
    logic                 active_out;
    logic                 error_out;

    modport master (
        output init, high_limit_in, low_limit_in, fifo_empty, fifo_full, fifo_error, dest_pause,
        input  fifo_read, grant_id, high_limit, low_limit, state_out, idle_out, active_out,
               error_out
    );

    modport slave (
        input  init, high_limit_in, low_limit_in, fifo_empty, fifo_full, fifo_error, dest_pause,
        output fifo_read, grant_id, high_limit, low_limit, state_out, idle_out, active_out,
               error_out
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: purely combinational round-robin picker.
//   eligible_i    : channels that may be read this cycle
//   prio_i        : eligible channels that preempt round-robin (lowest index wins)
//   ptr_i         : last granted index; search starts at ptr_i+1 and wraps
//   grant_o       : one-hot grant, zero when nothing is eligible
//   grant_id_o    : index of the grant (0 when none)
//   grant_valid_o : a grant was made
module rr_arbiter #(
    parameter int unsigned NUM_VC  = vc_sched_pkg::NumVcDef,
    parameter int unsigned GRANT_W = vc_sched_pkg::GRANT_W
) (
    input  logic [NUM_VC-1:0]  eligible_i,
    input  logic [NUM_VC-1:0]  prio_i,
    input  logic [GRANT_W-1:0] ptr_i,
    output logic [NUM_VC-1:0]  grant_o,
    output logic [GRANT_W-1:0] grant_id_o,
    output logic               grant_valid_o
);

    logic               found;
    logic [GRANT_W-1:0] cand;

    always_comb begin
        found      = 1'b0;
        cand       = '0;
        grant_id_o = '0;
        // First eligible index after the pointer, wrapping modulo NUM_VC.
        for (int unsigned off = 1; off <= NUM_VC; off++) begin
            cand = GRANT_W'((32'(ptr_i) + off) % NUM_VC);
            if (!found && eligible_i[cand]) begin
                found      = 1'b1;
                grant_id_o = cand;
            end
        end
        // Descending scan so the lowest priority index is the one left standing.
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            cand = GRANT_W'(i);
            if (prio_i[cand]) begin
                found      = 1'b1;
                grant_id_o = cand;
            end
        end
        grant_o             = '0;
        grant_o[grant_id_o] = found;
        grant_valid_o       = found;
    end

endmodule

// File: rtl/vc_read_scheduler.sv
// vc_read_scheduler: sequences reads from NUM_VC FIFOs onto one downstream path.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : vc_read_scheduler_if.slave (FIFO flags, thresholds, read enables, status)
// FSM RESET -> INIT (thresholds loaded every cycle) -> IDLE <-> ACTIVE; any FIFO error
// in IDLE/ACTIVE traps into a sticky ERROR that only reset clears.
// Optional build macro FULL_PRIORITY_EN: an eligible full FIFO preempts round-robin.
module vc_read_scheduler
    import vc_sched_pkg::*;
#(
    parameter int unsigned NUM_VC    = NumVcDef,
    parameter int unsigned ADDR_BITS = 3,
    parameter int unsigned HIGH      = 6,
    parameter int unsigned LOW       = 2
) (
    input logic                clk,
    input logic                reset,
    vc_read_scheduler_if.slave bus
);

    localparam int unsigned    GW     = idx_w(NUM_VC);
    localparam logic [GW-1:0]  PtrRst = GW'(NUM_VC - 1);

    logic [2:0]           state_q, state_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ADDR_BITS-1:0] high_q, high_d;
    logic [ADDR_BITS-1:0] low_q, low_d;

    logic [NUM_VC-1:0]    eligible;
    logic [NUM_VC-1:0]    prio;
    logic [NUM_VC-1:0]    arb_grant;
    logic [GW-1:0]        arb_id;
    logic                 arb_valid;
    logic [NUM_VC-1:0]    fifo_read;
    logic [GW-1:0]        grant_id;

    assign eligible = ~bus.fifo_empty & ~bus.dest_pause;

`ifdef FULL_PRIORITY_EN
    assign prio = eligible & bus.fifo_full;
`else
    assign prio = '0;
    logic unused_full;
    assign unused_full = ^bus.fifo_full;
`endif

    rr_arbiter #(
        .NUM_VC  (NUM_VC),
        .GRANT_W (GW)
    ) u_rr_arbiter (
        .eligible_i    (eligible),
        .prio_i        (prio),
        .ptr_i         (rr_ptr_q),
        .grant_o       (arb_grant),
        .grant_id_o    (arb_id),
        .grant_valid_o (arb_valid)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        high_d    = high_q;
        low_d     = low_q;
        fifo_read = '0;
        grant_id  = '0;
        case (state_q)
            StReset: state_d = StInit;
            StInit: begin
                high_d = bus.high_limit_in;
                low_d  = bus.low_limit_in;
                if (!bus.init) state_d = StIdle;
            end
            StIdle: begin
                if (|bus.fifo_error)   state_d = StError;
                else if (bus.init)     state_d = StInit;
                else if (|eligible)    state_d = StActive;
            end
            StActive: begin
                // Reads are issued from current-cycle eligibility: zero added latency.
                fifo_read = arb_grant;
                grant_id  = arb_id;
                if (arb_valid) rr_ptr_d = arb_id;
                if (|bus.fifo_error)                      state_d = StError;
                else if (bus.init)                        state_d = StInit;
                else if (!arb_valid && &bus.fifo_empty)   state_d = StIdle;
            end
            StError: state_d = StError;
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StReset;
            rr_ptr_q <= PtrRst;
            high_q   <= ADDR_BITS'(HIGH);
            low_q    <= ADDR_BITS'(LOW);
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            high_q   <= high_d;
            low_q    <= low_d;
        end
    end

    assign bus.fifo_read  = fifo_read;
    assign bus.grant_id   = grant_id;
    assign bus.high_limit = high_q;
    assign bus.low_limit  = low_q;
    assign bus.state_out  = state_q;
    assign bus.idle_out   = (state_q == StIdle);
    assign bus.active_out = (state_q == StActive);
    assign bus.error_out  = (state_q == StError);

endmodule
